// File: rtl/apb_fanout_bridge_if.sv
// Signal bundle for apb_fanout_bridge: upstream APB completer side plus the NSLV
// downstream requester side. The bridge uses 'slave'; its environment uses 'master'.
interface apb_fanout_bridge_if #(
   parameter int unsigned AWIDTH = 12,
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned SWIDTH = DWIDTH / 8,
   parameter int unsigned NSLV   = 4
);
   logic                     i_sel;
   logic                     i_enable;
   logic [AWIDTH-1:0]        i_addr;
   logic                     i_write;
   logic [DWIDTH-1:0]        i_wdata;
   logic [SWIDTH-1:0]        i_strb;
   logic [2:0]               i_prot;
   logic [DWIDTH-1:0]        o_rdata;
   logic                     o_ready;
   logic                     o_slverr;
   logic [NSLV-1:0]          o_m_sel;
   logic                     o_m_enable;
   logic [AWIDTH-1:0]        o_m_addr;
   logic                     o_m_write;
   logic [DWIDTH-1:0]        o_m_wdata;
   logic [SWIDTH-1:0]        o_m_strb;
   logic [2:0]               o_m_prot;
   logic [NSLV*DWIDTH-1:0]   i_m_rdata;
   logic [NSLV-1:0]          i_m_ready;
   logic [NSLV-1:0]          i_m_slverr;

   modport slave (
      input  i_sel, i_enable, i_addr, i_write, i_wdata, i_strb, i_prot,
      output o_rdata, o_ready, o_slverr,
      output o_m_sel, o_m_enable, o_m_addr, o_m_write, o_m_wdata, o_m_strb, o_m_prot,
      input  i_m_rdata, i_m_ready, i_m_slverr
   );

   modport master (
      output i_sel, i_enable, i_addr, i_write, i_wdata, i_strb, i_prot,
      input  o_rdata, o_ready, o_slverr,
      input  o_m_sel, o_m_enable, o_m_addr, o_m_write, o_m_wdata, o_m_strb, o_m_prot,
      output i_m_rdata, i_m_ready, i_m_slverr
   );
endinterface

// File: rtl/apb_fanout_bridge.sv
// APB4 1-to-NSLV fan-out bridge with registered downstream phases and address decode.
// Define APB_FANOUT_TIMEOUT_EN to abort ACCESS after TIMEOUT non-ready cycles.
module apb_fanout_bridge #(
   parameter int unsigned AWIDTH     = 12,
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned SWIDTH     = DWIDTH / 8,
   parameter int unsigned NSLV       = 4,
   parameter int unsigned SLV_AWIDTH = 10,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   apb_fanout_bridge_if.slave  apb
);

   localparam int unsigned IdxW  = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int unsigned HiLsb = SLV_AWIDTH + IdxW;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DWIDTH-1:0]   wdata_q, wdata_d;
   logic [SWIDTH-1:0]   strb_q, strb_d;
   logic [2:0]          prot_q, prot_d;
   logic [NSLV-1:0]     m_sel_q, m_sel_d;
   logic                m_enable_q, m_enable_d;
   logic [DWIDTH-1:0]   rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                slverr_q, slverr_d;

   logic                setup_req, req_err, timeout_hit;
   logic [IdxW-1:0]     req_idx;
   logic                sel_ready, sel_slverr;
   logic [DWIDTH-1:0]   sel_rdata;

   assign setup_req = apb.i_sel & ~apb.i_enable;
   assign req_idx   = apb.i_addr[SLV_AWIDTH +: IdxW];
   // Out-of-range index or any address bit above the slave-select field is a decode error.
   assign req_err   = (32'(req_idx) >= NSLV) || ((apb.i_addr >> HiLsb) != '0);

   assign sel_ready  = apb.i_m_ready[idx_q];
   assign sel_slverr = apb.i_m_slverr[idx_q];
   assign sel_rdata  = apb.i_m_rdata[32'(idx_q) * DWIDTH +: DWIDTH];

`ifdef APB_FANOUT_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign timeout_hit = (state_q == StAccess) && (cnt_q == CntW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == StAccess && !sel_ready && !timeout_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Without the counter the limit is not consumed anywhere.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (setup_req) state_d = req_err ? StResp : StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (sel_ready || timeout_hit) state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      idx_d      = idx_q;
      addr_d     = addr_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      prot_d     = prot_q;
      m_sel_d    = m_sel_q;
      m_enable_d = m_enable_q;
      rdata_d    = rdata_q;
      slverr_d   = slverr_q;
      ready_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (setup_req) begin
               idx_d   = req_idx;
               addr_d  = apb.i_addr;
               write_d = apb.i_write;
               wdata_d = apb.i_wdata;
               strb_d  = apb.i_write ? apb.i_strb : '0;
               prot_d  = apb.i_prot;
               if (req_err) begin
                  ready_d  = 1'b1;
                  slverr_d = 1'b1;
                  rdata_d  = '0;
               end else begin
                  m_sel_d          = '0;
                  m_sel_d[req_idx] = 1'b1;
                  m_enable_d       = 1'b0;
               end
            end
         end
         StSetup: m_enable_d = 1'b1;
         StAccess: begin
            if (sel_ready) begin
               m_sel_d    = '0;
               m_enable_d = 1'b0;
               ready_d    = 1'b1;
               slverr_d   = sel_slverr;
               rdata_d    = write_q ? '0 : sel_rdata;
            end else if (timeout_hit) begin
               m_sel_d    = '0;
               m_enable_d = 1'b0;
               ready_d    = 1'b1;
               slverr_d   = 1'b1;
               rdata_d    = '0;
            end
         end
         StResp:  ready_d = 1'b0;
         default: ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx_q      <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         strb_q     <= '0;
         prot_q     <= '0;
         m_sel_q    <= '0;
         m_enable_q <= 1'b0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         slverr_q   <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         prot_q     <= prot_d;
         m_sel_q    <= m_sel_d;
         m_enable_q <= m_enable_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         slverr_q   <= slverr_d;
      end
   end

   assign apb.o_rdata    = rdata_q;
   assign apb.o_ready    = ready_q;
   assign apb.o_slverr   = slverr_q;
   assign apb.o_m_sel    = m_sel_q;
   assign apb.o_m_enable = m_enable_q;
   assign apb.o_m_addr   = addr_q;
   assign apb.o_m_write  = write_q;
   assign apb.o_m_wdata  = wdata_q;
   assign apb.o_m_strb   = strb_q;
   assign apb.o_m_prot   = prot_q;

endmodule

// File: tb/tb_apb_fanout_bridge.sv
// Randomized bench for apb_fanout_bridge (3 slaves, 13-bit address, 1 KiB windows)
// checked against a transaction-level model of decode, latency and response.
module tb_apb_fanout_bridge;

   localparam int unsigned AW    = 13;
   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = 4;
   localparam int unsigned NS    = 3;
   localparam int unsigned SLVAW = 10;
   localparam int unsigned TMO   = 16;

   logic clk;
   logic rst;

   apb_fanout_bridge_if #(.AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW), .NSLV(NS)) bus ();

   apb_fanout_bridge #(
      .AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW), .NSLV(NS), .SLV_AWIDTH(SLVAW), .TIMEOUT(TMO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .apb   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Downstream slave models: the addressed slave answers after wait_cfg ACCESS cycles,
   // every other slave toggles ready/slverr randomly and must be ignored.
   int          wait_cfg   = 0;
   logic        slverr_cfg = 1'b0;
   logic [31:0] slv_rdata [NS];
   int          acc_cnt    = 0;
   logic [NS-1:0] noise_rdy = '0, noise_err = '0;

   always @(posedge clk) begin
      acc_cnt   <= (bus.o_m_enable && |bus.o_m_sel) ? acc_cnt + 1 : 0;
      noise_rdy <= NS'($urandom);
      noise_err <= NS'($urandom);
   end

   always_comb begin
      bus.i_m_ready  = '0;
      bus.i_m_slverr = '0;
      bus.i_m_rdata  = '0;
      for (int k = 0; k < NS; k++) begin
         if (bus.o_m_sel[k] && bus.o_m_enable) begin
            bus.i_m_ready[k]  = (acc_cnt >= wait_cfg);
            bus.i_m_slverr[k] = (acc_cnt >= wait_cfg) && slverr_cfg;
         end else begin
            bus.i_m_ready[k]  = noise_rdy[k];
            bus.i_m_slverr[k] = noise_err[k];
         end
         bus.i_m_rdata[k*DW +: DW] = slv_rdata[k];
      end
   end

   // What a slave observed when it completed a transfer.
   int          seen_cnt = 0;
   logic [AW-1:0] seen_addr;
   logic [31:0] seen_wdata;
   logic        seen_write;
   logic [2:0]  seen_prot;

   always @(posedge clk) begin
      if (bus.o_m_enable && |(bus.o_m_sel & bus.i_m_ready)) begin
         seen_cnt   <= seen_cnt + 1;
         seen_addr  <= bus.o_m_addr;
         seen_wdata <= bus.o_m_wdata;
         seen_write <= bus.o_m_write;
         seen_prot  <= bus.o_m_prot;
      end
   end

   logic [31:0] last_rdata = '0;

   task automatic check_zero(input string tag);
      check_eq({tag, "_ready"},  bus.o_ready, 0);
      check_eq({tag, "_slverr"}, bus.o_slverr, 0);
      check_eq({tag, "_rdata"},  bus.o_rdata, 0);
      check_eq({tag, "_msel"},   bus.o_m_sel, 0);
      check_eq({tag, "_men"},    bus.o_m_enable, 0);
      check_eq({tag, "_maddr"},  {bus.o_m_addr, bus.o_m_write, bus.o_m_prot, bus.o_m_strb}, 0);
      check_eq({tag, "_mwdata"}, bus.o_m_wdata, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_sel = 1'b0;
      bus.i_enable = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      last_rdata = '0;
   endtask

   task automatic idle(input int n);
      bus.i_sel = 1'b0;
      bus.i_enable = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_eq("idle_ready", bus.o_ready, 0);
         check_eq("idle_msel", bus.o_m_sel, 0);
         check_eq("rdata_hold", bus.o_rdata, last_rdata);
      end
   endtask

   // One upstream transfer; called just after a rising edge, returns just after one.
   task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input int w,
                       input logic serr);
      int          idx, exp_lat, cyc, limit, seen_before;
      logic        err, tmo, got;
      logic [NS-1:0] exp_sel;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
      idx = int'(addr) / (1 << SLVAW);
      err = (idx >= NS);
      tmo = 1'b0;
`ifdef APB_FANOUT_TIMEOUT_EN
      tmo = !err && (w >= TMO);
`endif
      for (int k = 0; k < NS; k++) slv_rdata[k] = $urandom;
      exp_sel    = err ? '0 : NS'(1 << idx);
      exp_lat    = err ? 1 : tmo ? 2 + TMO : (w > 500) ? 0 : 3 + w;
      exp_rdata  = (err || tmo || wr) ? 32'h0 : slv_rdata[idx];
      exp_slverr = err || tmo || serr;
      limit      = (exp_lat == 0) ? 200 : exp_lat + 4;
      wait_cfg   = w;
      slverr_cfg = serr;
      seen_before = seen_cnt;
      bus.i_sel = 1'b1;
      bus.i_enable = 1'b0;
      bus.i_addr = addr;
      bus.i_write = wr;
      bus.i_wdata = wd;
      bus.i_strb = st;
      bus.i_prot = pr;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) bus.i_enable = 1'b1;
         @(negedge clk);
         if (cyc == 1) begin
            check_eq("msel", bus.o_m_sel, exp_sel);
            if (!err) check_eq("men_setup", bus.o_m_enable, 0);
         end
         if (cyc == 2 && !err) begin
            check_eq("men_access", bus.o_m_enable, 1);
            check_eq("mstrb", bus.o_m_strb, wr ? st : 4'h0);
            check_eq("maddr", bus.o_m_addr, addr);
            check_eq("mwrite", bus.o_m_write, wr);
         end
         if (bus.o_ready) got = 1'b1;
      end
      if (exp_lat == 0) begin
         check_eq("hang_ready", got, 0);
         return;
      end
      check_eq("latency", got ? cyc : 0, exp_lat);
      if (got) begin
         check_eq("rdata", bus.o_rdata, exp_rdata);
         check_eq("slverr", bus.o_slverr, exp_slverr);
         last_rdata = exp_rdata;
      end
      check_eq("slv_done", seen_cnt - seen_before, (err || tmo) ? 0 : 1);
      if (!err && !tmo && got) begin
         check_eq("seen_addr", seen_addr, addr);
         check_eq("seen_prot", seen_prot, pr);
         if (wr) check_eq("seen_wdata", seen_wdata, wd);
      end
      @(posedge clk); #1;
      bus.i_sel = 1'b0;
      bus.i_enable = 1'b0;
   endtask

   task automatic reset_in_access();
      for (int k = 0; k < NS; k++) slv_rdata[k] = $urandom;
      wait_cfg = 1000;
      bus.i_sel = 1'b1;
      bus.i_enable = 1'b0;
      bus.i_addr = 13'h800;
      bus.i_write = 1'b1;
      bus.i_strb = 4'hF;
      @(posedge clk); #1;
      bus.i_enable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("pre_rst_msel", bus.o_m_sel, 3'b100);
      rst = 1'b1;
      bus.i_sel = 1'b0;
      bus.i_enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("mid_rst");
      last_rdata = '0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, off, w;
      logic hi;
      rst = 1'b1;
      bus.i_sel = 1'b0;
      bus.i_enable = 1'b0;
      bus.i_addr = '0;
      bus.i_write = 1'b0;
      bus.i_wdata = '0;
      bus.i_strb = '0;
      bus.i_prot = '0;
      for (int k = 0; k < NS; k++) slv_rdata[k] = '0;
      @(posedge clk); #1;
      do_reset();

      xfer(13'h404, 1'b1, 32'h0000_ABCD, 4'hF, 3'b000, 0, 1'b0);
      idle(1);
      xfer(13'h810, 1'b0, 32'h0, 4'hF, 3'b001, 3, 1'b0);
      idle(2);
      xfer(13'hC00, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0);
      xfer(13'h1404, 1'b1, 32'h5555, 4'h3, 3'b010, 0, 1'b0);
      idle(1);
      xfer(13'h010, 1'b0, 32'h0, 4'hF, 3'b000, 1, 1'b1);
      xfer(13'h020, 1'b1, 32'hCAFE_F00D, 4'h5, 3'b111, 0, 1'b0);
      idle(1);
      xfer(13'h444, 1'b0, 32'h0, 4'hF, 3'b000, TMO - 1, 1'b0);
      xfer(13'h448, 1'b0, 32'h0, 4'hF, 3'b000, TMO, 1'b0);
      idle(1);

      for (int n = 0; n < 60; n++) begin
         idx = $urandom_range(0, 3);
         off = $urandom_range(0, 1023);
         hi  = ($urandom_range(0, 7) == 0);
         w   = $urandom_range(0, 4);
         xfer(AW'(idx * 1024 + off + (hi ? 4096 : 0)), 1'($urandom_range(0, 1)), $urandom,
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), w,
              ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0) idle(1 + $urandom_range(0, 2));
      end

      reset_in_access();
      xfer(13'h0FC, 1'b0, 32'h0, 4'hF, 3'b000, 2, 1'b0);
      idle(1);

      xfer(13'h900, 1'b0, 32'h0, 4'hF, 3'b000, 100000, 1'b0);
      do_reset();
      xfer(13'h600, 1'b1, 32'h1234_5678, 4'hC, 3'b001, 0, 1'b0);
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
